mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage, and the producer for the writeback stage.
- Takes the registered execute outputs and issues the data-SRAM request for loads and stores.
- Collects the multiplier/divider responses, aligns and extends load data, and passes exception/ertn state through.
- Presents a one-entry valid/ready pipeline register to writeback, plus a forwarding/interlock port to decode.

Parameters:
- PC_RESET, 32'h1c000000, reset value of pc_out.
- MAX_CANCEL, 3, maximum outstanding flushed data responses tracked; cancel counter is 2 bits.

Ports:
- clk  in  1  single clock (already decided).
- resetn  in  1  reset, asynchronous, active-low (already decided).
- in_valid  in  1  execute stage holds a valid instruction.
- in_ready  out  1  stage can accept.
- out_valid  out  1  writeback register holds a valid instruction.
- out_ready  in  1  writeback accepts.
- mem_flush  in  1  exception/ertn flush from writeback.
- pc, result  in  32 each  instruction PC; ALU/CSR result, doubling as the memory address.
- mem_op  in  8  one-hot: [0]ld.b [1]ld.h [2]ld.w [3]ld.bu [4]ld.hu [5]st.b [6]st.h [7]st.w.
- mul_op  in  3  one-hot: [0]mul.w [1]mulh.w [2]mulh.wu.
- div_op  in  4  one-hot: [0]div.w [1]mod.w [2]div.wu [3]mod.wu.
- res_from_mul, res_from_div, res_from_mem, res_from_csr, gr_we, mem_we  in  1 each.
- dest  in  5  destination register.
- rkd_value  in  32  store data.
- has_exception, ertn  in  1 each.
- ecode, esubcode, exception_maddr  in  6 / 9 / 32.
- data_req, data_wr  out  1 each.
- data_size  out  2  encoding 0/1/2 = byte/half/word.
- data_wstrb  out  4  byte write strobes.
- data_addr, data_wdata  out  32 each.
- data_addr_ok, data_data_ok  in  1 each.
- data_rdata  in  32.
- mul_resp_valid  in  1;  mul_resp_ready  out  1;  mul_result  in  64.
- div_resp_valid  in  1;  div_resp_ready  out  1;  div_result  in  64  {remainder, quotient}.
- wb_value_out, pc_out  out  32 each.
- dest_out  out  5.
- gr_we_out, has_exception_out, ertn_out  out  1 each.
- ecode_out, esubcode_out, exception_maddr_out  out  6 / 9 / 32.
- fwd_valid, fwd_pending  out  1 each.
- fwd_dest  out  5.
- fwd_value  out  32.

Behaviour:
- Reset (resetn low, asynchronous): every registered output goes to 0 except pc_out = PC_RESET; FSM to IDLE; cancel_cnt = 0.
- Request suppression: no memory request is issued, and no mul/div response is consumed, when has_exception or mem_flush is high.
- FSM states:
  - IDLE: on in_valid & res_from_mem|mem_we & !has_exception & !mem_flush & cancel_cnt==0, go to REQ.
  - REQ: data_req = 1 with stable addr/size/wstrb/wdata. data_addr_ok -> WAIT. mem_flush before addr_ok -> IDLE with data_req dropped the same cycle.
  - WAIT: data_data_ok -> DONE, latching data_rdata into rbuf.
  - DONE: hold until the instruction leaves the stage, then IDLE.
- Stores and loads wait for data_ok alike.
- Flush after addr_ok (mem_flush in WAIT, or same cycle as addr_ok in REQ): cancel_cnt increments and the FSM returns to IDLE.
- Cancelled responses: while cancel_cnt != 0, each data_data_ok is discarded and decrements cancel_cnt. No new request is issued until cancel_cnt == 0.
- Saturation: increment and decrement in the same cycle leave cancel_cnt unchanged; cancel_cnt saturates at MAX_CANCEL (assertion fires if exceeded).
- Size/strobe/wdata:
  - byte: wstrb = 1 << addr[1:0], wdata = {4{rkd[7:0]}}.
  - half: wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{rkd[15:0]}}.
  - word: wstrb = 4'hf.
  - loads: wstrb = 0.
  - data_addr = result.
- Load data: select byte/half by addr[1:0]/addr[1], then sign-extend (ld.b/ld.h) or zero-extend (bu/hu).
- Mul/div:
  - mul_resp_ready = in_valid & res_from_mul & !has_exception & !mem_flush & out_ready; same rule for div.
  - mul.w takes mul_result[31:0]; mulh.w and mulh.wu take [63:32].
  - div ops take quotient; mod ops take remainder.
- ready_go = has_exception | mem_flush | (mem op: DONE or (WAIT & data_ok)) | (mul: mul handshake) | (div: div handshake) | otherwise 1.
- in_ready = !in_valid | (ready_go & out_ready).
- Output register:
  - out_valid <= in_valid & ready_go & !mem_flush when out_ready.
  - Payload registers load on in_valid & ready_go & out_ready.
  - wb_value priority: mem, mul, div, then result.
- Exception fields pass through unchanged.
- Forwarding: fwd_valid = in_valid & gr_we & dest != 0. fwd_pending = fwd_valid & (res_from_mem|res_from_mul|res_from_div) & !ready_go.
- Simultaneous mem_flush and out_ready: out_valid = 0, and no request is started.

Decomposition:
- Shared package holds:
  - mem_op/mul_op/div_op bit indices;
  - data_size encodings;
  - PC reset constant;
  - FSM state typedef {IDLE, REQ, WAIT, DONE}.
- One natural sub-module, mem_load_align: combinational addr[1:0] + mem_op + rdata -> extended 32-bit value.

Test Plan:
- ld.b at addr 0x1c000003, rdata 0x80112233, addr_ok and data_ok one cycle apart -> wb_value_out 0xffffff80, data_size 0, wstrb 0; out_valid 3 cycles after in_valid.
- st.h at 0x1000_0002 with rkd 0x1234abcd -> data_wr 1, wstrb 4'b1100, wdata 0xabcdabcd; out_valid only after data_ok.
- ld.w flushed in WAIT, then next ld.w issued -> first data_ok (0xdeadbeef) discarded, cancel_cnt 1->0; the second load's data is written back; no extra out_valid.
- mulh.wu with mul_result 0x00000003_00000001 and resp_valid delayed 4 cycles -> fwd_pending high 4 cycles, wb_value_out 0x3.
- has_exception with ecode 0x9, res_from_mem set -> no data_req ever; has_exception_out 1, ecode_out 0x9 next cycle.
- resetn deasserted while in REQ -> data_req 0 immediately (asynchronous), pc_out 0x1c000000, out_valid 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared op indices, size encodings, reset PC and FSM states
package mem_stage_pkg;

  localparam int OP_LD_B  = 0;
  localparam int OP_LD_H  = 1;
  localparam int OP_LD_W  = 2;
  localparam int OP_LD_BU = 3;
  localparam int OP_LD_HU = 4;
  localparam int OP_ST_B  = 5;
  localparam int OP_ST_H  = 6;
  localparam int OP_ST_W  = 7;

  localparam int MUL_W  = 0;
  localparam int MUL_H  = 1;
  localparam int MUL_HU = 2;

  localparam int DIV_W  = 0;
  localparam int MOD_W  = 1;
  localparam int DIV_WU = 2;
  localparam int MOD_WU = 3;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [31:0] PC_RESET_VAL = 32'h1c00_0000;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_e;

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - selects the addressed byte/half of load data and extends it
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [4:0]  i_ld_op,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_value = 32'h0;
    if (i_ld_op[OP_LD_B])       o_value = {{24{w_byte[7]}}, w_byte};
    else if (i_ld_op[OP_LD_BU]) o_value = {24'h0, w_byte};
    else if (i_ld_op[OP_LD_H])  o_value = {{16{w_half[15]}}, w_half};
    else if (i_ld_op[OP_LD_HU]) o_value = {16'h0, w_half};
    else if (i_ld_op[OP_LD_W])  o_value = i_rdata;
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage: data SRAM requests, mul/div collect, writeback register
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = PC_RESET_VAL,
  parameter int          MAX_CANCEL = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        mem_flush,
  input  logic [31:0] pc,
  input  logic [31:0] result,
  input  logic [7:0]  mem_op,
  input  logic [2:0]  mul_op,
  input  logic [3:0]  div_op,
  input  logic        res_from_mul,
  input  logic        res_from_div,
  input  logic        res_from_mem,
  input  logic        res_from_csr,
  input  logic        gr_we,
  input  logic        mem_we,
  input  logic [4:0]  dest,
  input  logic [31:0] rkd_value,
  input  logic        has_exception,
  input  logic        ertn,
  input  logic [5:0]  ecode,
  input  logic [8:0]  esubcode,
  input  logic [31:0] exception_maddr,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  input  logic        mul_resp_valid,
  output logic        mul_resp_ready,
  input  logic [63:0] mul_result,
  input  logic        div_resp_valid,
  output logic        div_resp_ready,
  input  logic [63:0] div_result,
  output logic [31:0] wb_value_out,
  output logic [31:0] pc_out,
  output logic [4:0]  dest_out,
  output logic        gr_we_out,
  output logic        has_exception_out,
  output logic        ertn_out,
  output logic [5:0]  ecode_out,
  output logic [8:0]  esubcode_out,
  output logic [31:0] exception_maddr_out,
  output logic        fwd_valid,
  output logic        fwd_pending,
  output logic [4:0]  fwd_dest,
  output logic [31:0] fwd_value
);

  localparam logic [1:0] LP_MAX_CANCEL = 2'(MAX_CANCEL);

  mem_state_e  r_state;
  logic [1:0]  r_cancel_cnt;
  logic [31:0] r_rbuf;

  logic        w_block, w_is_mem, w_is_byte, w_is_half, w_start;
  logic        w_mem_done, w_mul_hs, w_div_hs, w_ready_go, w_leave;
  logic        w_cancel_inc, w_cancel_dec;
  logic [31:0] w_rdata, w_load_val, w_mul_val, w_div_val, w_wb_value;

  assign w_block   = has_exception | mem_flush;
  assign w_is_mem  = res_from_mem | mem_we;
  assign w_is_byte = mem_op[OP_LD_B] | mem_op[OP_LD_BU] | mem_op[OP_ST_B];
  assign w_is_half = mem_op[OP_LD_H] | mem_op[OP_LD_HU] | mem_op[OP_ST_H];
  assign w_start   = in_valid & w_is_mem & ~w_block & (r_cancel_cnt == 2'd0);

  // Request is a pure function of state so an async reset drops it immediately.
  assign data_req  = (r_state == REQ) & ~w_block;
  assign data_wr   = mem_we;
  assign data_addr = result;
  assign data_size = w_is_byte ? SIZE_BYTE : (w_is_half ? SIZE_HALF : SIZE_WORD);

  always_comb begin
    data_wstrb = 4'h0;
    data_wdata = rkd_value;
    if (w_is_byte) data_wdata = {4{rkd_value[7:0]}};
    else if (w_is_half) data_wdata = {2{rkd_value[15:0]}};
    if (mem_we) begin
      if (w_is_byte)      data_wstrb = 4'b0001 << result[1:0];
      else if (w_is_half) data_wstrb = result[1] ? 4'b1100 : 4'b0011;
      else                data_wstrb = 4'hf;
    end
  end

  assign mul_resp_ready = in_valid & res_from_mul & ~w_block & out_ready;
  assign div_resp_ready = in_valid & res_from_div & ~w_block & out_ready;
  assign w_mul_hs       = mul_resp_valid & mul_resp_ready;
  assign w_div_hs       = div_resp_valid & div_resp_ready;
  assign w_mem_done     = (r_state == DONE) | ((r_state == WAIT) & data_data_ok);

  assign w_ready_go = w_block |
                      (w_is_mem     ? w_mem_done :
                       res_from_mul ? w_mul_hs   :
                       res_from_div ? w_div_hs   : 1'b1);
  assign in_ready   = ~in_valid | (w_ready_go & out_ready);
  assign w_leave    = in_valid & w_ready_go & out_ready;

  assign w_rdata = (r_state == DONE) ? r_rbuf : data_rdata;

  mem_load_align u_align (
    .i_addr_lo (result[1:0]),
    .i_ld_op   (mem_op[4:0]),
    .i_rdata   (w_rdata),
    .o_value   (w_load_val)
  );

  assign w_mul_val = mul_op[MUL_W] ? mul_result[31:0] :
                     (mul_op[MUL_H] | mul_op[MUL_HU]) ? mul_result[63:32] : 32'h0;
  assign w_div_val = (div_op[DIV_W] | div_op[DIV_WU]) ? div_result[31:0] :
                     (div_op[MOD_W] | div_op[MOD_WU]) ? div_result[63:32] : 32'h0;

  // CSR results already arrive in result, so they share the default path.
  assign w_wb_value = res_from_mem ? w_load_val :
                      res_from_mul ? w_mul_val  :
                      res_from_div ? w_div_val  :
                      (res_from_csr ? result : result);

  assign fwd_valid   = in_valid & gr_we & (dest != 5'd0);
  assign fwd_pending = fwd_valid & (res_from_mem | res_from_mul | res_from_div) & ~w_ready_go;
  assign fwd_dest    = dest;
  assign fwd_value   = w_wb_value;

  // A response owed to a flushed request must be swallowed before the next request.
  assign w_cancel_inc = mem_flush & (((r_state == REQ) & data_addr_ok) |
                                     ((r_state == WAIT) & ~data_data_ok));
  assign w_cancel_dec = (r_cancel_cnt != 2'd0) & data_data_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_cancel_cnt <= 2'd0;
      r_rbuf       <= 32'h0;
    end else begin
      case (r_state)
        IDLE: if (w_start) r_state <= REQ;
        REQ: begin
          if (w_block)           r_state <= IDLE;
          else if (data_addr_ok) r_state <= WAIT;
        end
        WAIT: begin
          if (mem_flush) r_state <= IDLE;
          else if (data_data_ok) begin
            r_rbuf  <= data_rdata;
            r_state <= w_leave ? IDLE : DONE;
          end
        end
        DONE: if (w_leave | mem_flush) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (w_cancel_inc & ~w_cancel_dec) begin
        assert (r_cancel_cnt != LP_MAX_CANCEL);
        if (r_cancel_cnt != LP_MAX_CANCEL) r_cancel_cnt <= r_cancel_cnt + 2'd1;
      end else if (w_cancel_dec & ~w_cancel_inc) begin
        r_cancel_cnt <= r_cancel_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid           <= 1'b0;
      wb_value_out        <= 32'h0;
      pc_out              <= PC_RESET;
      dest_out            <= 5'd0;
      gr_we_out           <= 1'b0;
      has_exception_out   <= 1'b0;
      ertn_out            <= 1'b0;
      ecode_out           <= 6'd0;
      esubcode_out        <= 9'd0;
      exception_maddr_out <= 32'h0;
    end else begin
      if (out_ready) out_valid <= in_valid & w_ready_go & ~mem_flush;
      if (w_leave) begin
        wb_value_out        <= w_wb_value;
        pc_out              <= pc;
        dest_out            <= dest;
        gr_we_out           <= gr_we;
        has_exception_out   <= has_exception;
        ertn_out            <= ertn;
        ecode_out           <= ecode;
        esubcode_out        <= esubcode;
        exception_maddr_out <= exception_maddr;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed and randomized self-checking bench for mem_stage
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid, in_ready, out_valid, out_ready, mem_flush;
  logic [31:0] pc, result, rkd_value, exception_maddr;
  logic [7:0]  mem_op;
  logic [2:0]  mul_op;
  logic [3:0]  div_op;
  logic        res_from_mul, res_from_div, res_from_mem, res_from_csr, gr_we, mem_we;
  logic [4:0]  dest;
  logic        has_exception, ertn;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mul_resp_valid, mul_resp_ready, div_resp_valid, div_resp_ready;
  logic [63:0] mul_result, div_result;
  logic [31:0] wb_value_out, pc_out, exception_maddr_out, fwd_value;
  logic [4:0]  dest_out, fwd_dest;
  logic        gr_we_out, has_exception_out, ertn_out, fwd_valid, fwd_pending;
  logic [5:0]  ecode_out;
  logic [8:0]  esubcode_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .mem_flush(mem_flush),
    .pc(pc), .result(result), .mem_op(mem_op), .mul_op(mul_op), .div_op(div_op),
    .res_from_mul(res_from_mul), .res_from_div(res_from_div), .res_from_mem(res_from_mem),
    .res_from_csr(res_from_csr), .gr_we(gr_we), .mem_we(mem_we), .dest(dest),
    .rkd_value(rkd_value), .has_exception(has_exception), .ertn(ertn), .ecode(ecode),
    .esubcode(esubcode), .exception_maddr(exception_maddr),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mul_resp_valid(mul_resp_valid), .mul_resp_ready(mul_resp_ready), .mul_result(mul_result),
    .div_resp_valid(div_resp_valid), .div_resp_ready(div_resp_ready), .div_result(div_result),
    .wb_value_out(wb_value_out), .pc_out(pc_out), .dest_out(dest_out), .gr_we_out(gr_we_out),
    .has_exception_out(has_exception_out), .ertn_out(ertn_out), .ecode_out(ecode_out),
    .esubcode_out(esubcode_out), .exception_maddr_out(exception_maddr_out),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_dest(fwd_dest), .fwd_value(fwd_value)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    in_valid = 0; mem_flush = 0; pc = 0; result = 0; mem_op = 0; mul_op = 0; div_op = 0;
    res_from_mul = 0; res_from_div = 0; res_from_mem = 0; res_from_csr = 0;
    gr_we = 0; mem_we = 0; dest = 0; rkd_value = 0; has_exception = 0; ertn = 0;
    ecode = 0; esubcode = 0; exception_maddr = 0; data_addr_ok = 0; data_data_ok = 0;
    data_rdata = 0; mul_resp_valid = 0; mul_result = 0; div_resp_valid = 0; div_result = 0;
    out_ready = 1;
  endtask

  function automatic logic [31:0] ref_load(input int op, input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * int'(addr[1:0]))) & 32'hff;
    h = (rd >> (16 * int'(addr[1]))) & 32'hffff;
    case (op)
      0: return (b ^ 32'h80) - 32'h80;
      1: return (h ^ 32'h8000) - 32'h8000;
      3: return b;
      4: return h;
      default: return rd;
    endcase
  endfunction

  // kind: 0 alu, 1 load, 2 store, 3 mul, 4 div
  task automatic run_one(input int kind);
    int op, nbytes, wa, wd, wm, n;
    bit got_a, got_d, req_seen, left;
    logic [31:0] exp_wb, rd, exp_wdata;
    logic [1:0] exp_size;
    logic [3:0] exp_strb;
    op = 0; nbytes = 4; got_a = 0; got_d = 0; req_seen = 0; left = 0; n = 0;
    exp_size = 2'd2; exp_strb = 4'h0; exp_wdata = 32'h0;
    wa = $urandom_range(0, 2); wd = $urandom_range(0, 3); wm = $urandom_range(0, 4);
    rd = $urandom;
    in_valid = 1; pc = $urandom; result = $urandom; rkd_value = $urandom;
    dest = 5'($urandom_range(1, 31)); gr_we = (kind != 2);
    if (kind == 1 || kind == 2) begin
      op = (kind == 1) ? $urandom_range(0, 4) : $urandom_range(5, 7);
      mem_op = 8'(1 << op);
      nbytes = (op == 0 || op == 3 || op == 5) ? 1 : ((op == 1 || op == 4 || op == 6) ? 2 : 4);
      exp_size = (nbytes == 1) ? 2'd0 : ((nbytes == 2) ? 2'd1 : 2'd2);
      result = result & ~(32'(nbytes) - 32'd1);
      if (kind == 2) begin
        exp_strb  = 4'(((1 << nbytes) - 1) << (int'(result[1:0]) & ~(nbytes - 1)));
        exp_wdata = (nbytes == 1) ? (rkd_value & 32'hff) * 32'h01010101 :
                    (nbytes == 2) ? (rkd_value & 32'hffff) * 32'h00010001 : rkd_value;
        mem_we = 1;
      end else begin
        res_from_mem = 1;
      end
    end
    case (kind)
      1: exp_wb = ref_load(op, result, rd);
      3: begin
        op = $urandom_range(0, 2); mul_op = 3'(1 << op); res_from_mul = 1;
        mul_result = {32'($urandom), 32'($urandom)};
        exp_wb = (op == 0) ? mul_result[31:0] : mul_result[63:32];
      end
      4: begin
        op = $urandom_range(0, 3); div_op = 4'(1 << op); res_from_div = 1;
        div_result = {32'($urandom), 32'($urandom)};
        exp_wb = (op == 0 || op == 2) ? div_result[31:0] : div_result[63:32];
      end
      default: exp_wb = result;
    endcase
    while (!left && n < 60) begin
      out_ready = ($urandom_range(0, 3) != 0);
      data_addr_ok = 0; data_data_ok = 0; data_rdata = $urandom;
      #1;
      if (data_req) begin
        if (!req_seen) begin
          chk("rnd_req_addr", data_addr, result);
          chk("rnd_req_wr", data_wr, kind == 2);
          chk("rnd_req_size", data_size, exp_size);
          chk("rnd_req_wstrb", data_wstrb, exp_strb);
          if (kind == 2) chk("rnd_req_wdata", data_wdata, exp_wdata);
        end
        req_seen = 1;
        if (wa == 0) begin data_addr_ok = 1; got_a = 1; end else wa--;
      end else if (got_a && !got_d) begin
        if (wd == 0) begin data_data_ok = 1; data_rdata = rd; got_d = 1; end else wd--;
      end
      if (kind == 3) begin if (wm == 0) mul_resp_valid = 1; else wm--; end
      if (kind == 4) begin if (wm == 0) div_resp_valid = 1; else wm--; end
      #1;
      left = in_ready;
      @(negedge clk);
      n++;
    end
    chk("rnd_left", left, 1);
    chk("rnd_mem_req_seen", req_seen, (kind == 1 || kind == 2));
    #1;
    chk("rnd_out_valid", out_valid, 1);
    chk("rnd_wb_value", wb_value_out, exp_wb);
    chk("rnd_pc_out", pc_out, pc);
    chk("rnd_dest_out", dest_out, dest);
    clear_in();
  endtask

  initial begin
    clear_in();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pc_out", pc_out, 32'h1c000000);
    chk("rst_wb_value", wb_value_out, 0);
    chk("rst_data_req", data_req, 0);
    resetn = 1;

    // ld.b with addr_ok and data_ok on consecutive cycles
    @(negedge clk);
    in_valid = 1; res_from_mem = 1; mem_op = 8'h01; result = 32'h1c000003;
    pc = 32'h1c000100; gr_we = 1; dest = 5'd5;
    #1;
    chk("ldb_idle_no_req", data_req, 0);
    chk("ldb_in_ready_low", in_ready, 0);
    chk("ldb_fwd_pending", fwd_pending, 1);
    @(negedge clk); #1;
    chk("ldb_req", data_req, 1);
    chk("ldb_addr", data_addr, 32'h1c000003);
    chk("ldb_size", data_size, 0);
    chk("ldb_wstrb", data_wstrb, 0);
    chk("ldb_wr", data_wr, 0);
    data_addr_ok = 1;
    @(negedge clk);
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h80112233;
    #1;
    chk("ldb_req_dropped", data_req, 0);
    chk("ldb_fwd_value", fwd_value, 32'hffffff80);
    chk("ldb_in_ready", in_ready, 1);
    chk("ldb_out_valid_early", out_valid, 0);
    @(negedge clk);
    clear_in(); #1;
    chk("ldb_out_valid", out_valid, 1);
    chk("ldb_wb_value", wb_value_out, 32'hffffff80);
    chk("ldb_dest_out", dest_out, 5);
    chk("ldb_pc_out", pc_out, 32'h1c000100);

    // st.h at upper half, addr_ok delayed one cycle, data_ok delayed one cycle
    @(negedge clk);
    in_valid = 1; mem_we = 1; mem_op = 8'h40; result = 32'h10000002;
    rkd_value = 32'h1234abcd; pc = 32'h1c000104;
    @(negedge clk); #1;
    chk("sth_req", data_req, 1);
    chk("sth_wr", data_wr, 1);
    chk("sth_wstrb", data_wstrb, 4'b1100);
    chk("sth_wdata", data_wdata, 32'habcdabcd);
    chk("sth_size", data_size, 1);
    @(negedge clk); #1;
    chk("sth_req_hold", data_req, 1);
    data_addr_ok = 1;
    @(negedge clk); data_addr_ok = 0; #1;
    chk("sth_wait_not_ready", in_ready, 0);
    @(negedge clk); data_data_ok = 1; #1;
    chk("sth_no_early_valid", out_valid, 0);
    chk("sth_ready", in_ready, 1);
    @(negedge clk); clear_in(); #1;
    chk("sth_out_valid", out_valid, 1);
    chk("sth_pc_out", pc_out, 32'h1c000104);

    // ld.w flushed in WAIT; its late response must be swallowed
    @(negedge clk);
    in_valid = 1; res_from_mem = 1; mem_op = 8'h04; result = 32'h100; gr_we = 1; dest = 5'd9;
    @(negedge clk); #1;
    chk("cxl_req1", data_req, 1);
    data_addr_ok = 1;
    @(negedge clk);
    data_addr_ok = 0; in_valid = 0; mem_flush = 1;
    @(negedge clk);
    mem_flush = 0; in_valid = 1; result = 32'h200; pc = 32'h1c000108; #1;
    chk("cxl_flushed_no_valid", out_valid, 0);
    chk("cxl_blocked_req", data_req, 0);
    @(negedge clk);
    data_data_ok = 1; data_rdata = 32'hdeadbeef; #1;
    chk("cxl_discard_not_ready", in_ready, 0);
    chk("cxl_discard_no_req", data_req, 0);
    @(negedge clk);
    data_data_ok = 0; #1;
    chk("cxl_idle_after_discard", data_req, 0);
    chk("cxl_no_extra_valid", out_valid, 0);
    @(negedge clk); #1;
    chk("cxl_req2", data_req, 1);
    chk("cxl_req2_addr", data_addr, 32'h200);
    data_addr_ok = 1;
    @(negedge clk);
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h11223344; #1;
    chk("cxl_still_no_valid", out_valid, 0);
    @(negedge clk); clear_in(); #1;
    chk("cxl_out_valid", out_valid, 1);
    chk("cxl_wb_value", wb_value_out, 32'h11223344);
    chk("cxl_pc_out", pc_out, 32'h1c000108);
    @(negedge clk); #1;
    chk("cxl_single_valid", out_valid, 0);

    // mulh.wu with response delayed 4 cycles
    @(negedge clk);
    in_valid = 1; res_from_mul = 1; mul_op = 3'b100; mul_result = 64'h00000003_00000001;
    gr_we = 1; dest = 5'd7; pc = 32'h1c00010c;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mul_pending", fwd_pending, 1);
      @(negedge clk);
    end
    mul_resp_valid = 1; #1;
    chk("mul_resp_ready", mul_resp_ready, 1);
    chk("mul_pending_clear", fwd_pending, 0);
    chk("mul_fwd_value", fwd_value, 32'h3);
    @(negedge clk); clear_in(); #1;
    chk("mul_out_valid", out_valid, 1);
    chk("mul_wb_value", wb_value_out, 32'h3);

    // load carrying an exception never touches memory
    @(negedge clk);
    in_valid = 1; has_exception = 1; ecode = 6'h9; esubcode = 9'h3; exception_maddr = 32'h0abc;
    res_from_mem = 1; mem_op = 8'h04; pc = 32'h1c000110; #1;
    chk("exc_no_req", data_req, 0);
    chk("exc_ready", in_ready, 1);
    @(negedge clk); clear_in(); #1;
    chk("exc_out_valid", out_valid, 1);
    chk("exc_has_exception_out", has_exception_out, 1);
    chk("exc_ecode_out", ecode_out, 6'h9);
    chk("exc_esubcode_out", esubcode_out, 9'h3);
    chk("exc_maddr_out", exception_maddr_out, 32'h0abc);
    chk("exc_no_req_after", data_req, 0);
    @(negedge clk); #1;
    chk("exc_no_req_later", data_req, 0);

    // flush together with out_ready: nothing written back, nothing requested
    @(negedge clk);
    in_valid = 1; res_from_mem = 1; mem_op = 8'h04; result = 32'h300; mem_flush = 1; #1;
    chk("fl_ready", in_ready, 1);
    chk("fl_no_req", data_req, 0);
    @(negedge clk); clear_in(); #1;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_no_req_after", data_req, 0);

    for (int i = 0; i < 40; i++) run_one($urandom_range(0, 4));

    // asynchronous reset while a request is outstanding
    @(negedge clk);
    in_valid = 1; res_from_mem = 1; mem_op = 8'h04; result = 32'h400; pc = 32'h1c000200;
    @(negedge clk); #1;
    chk("rst_req_before", data_req, 1);
    #1; resetn = 0; #1;
    chk("rst_req_dropped", data_req, 0);
    chk("rst_async_pc_out", pc_out, 32'h1c000000);
    chk("rst_async_out_valid", out_valid, 0);
    clear_in();
    @(negedge clk); resetn = 1;
    @(negedge clk); #1;
    chk("rst_idle_after", data_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
